// File: rtl/prescaled_counter.sv
// -----------------------------------------------------------------------------
// prescaled_counter
//
// Up/down counter that advances once every CYCLES_PER_TICK enabled clock
// cycles. The internal prescaler only advances on cycles where ce=1. When
// it reaches its last value, that edge is a "step edge": the prescaler
// returns to 0 and the counter moves one step in the direction given by dir.
// At its bounds the counter either wraps (SATURATE=0) or holds (SATURATE=1).
//
// Parameters
//   WIDTH            counter width in bits (1..32)
//   CYCLES_PER_TICK  enabled clk cycles per count step (1..2^31-1)
//   SATURATE         0 = wrap at bounds, 1 = hold at bounds
//
// Ports
//   clk         single clock; all state changes on its rising edge
//   rst         synchronous active-high reset; highest priority
//   ce          clock enable for the prescaler and the count step
//   dir         step direction: 1 = up, 0 = down (sampled on the step edge)
//   load        synchronous load strobe; wins over a coincident step
//   load_value  value loaded into count when load=1
//   count       registered counter value
//   tick        one-cycle pulse, high in the cycle count first shows a step
//   tc          one-cycle terminal-count pulse, high with tick when the step
//               wrapped (wrap mode) or was attempted at a bound (saturate mode)
// -----------------------------------------------------------------------------
module prescaled_counter #(
  parameter int WIDTH           = 4,
  parameter int CYCLES_PER_TICK = 125000000,
  parameter bit SATURATE        = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  // A divide-by-1 still needs a one-bit prescaler so the vector is legal;
  // it simply never leaves 0, which makes every enabled edge a step edge.
  localparam int PW = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_TICK - 1);

  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_next;
  logic [WIDTH-1:0] count_next;
  logic             tick_next;
  logic             tc_next;
  logic             at_bound;

  // The bound that matters is the one we are stepping towards.
  assign at_bound = dir ? (count == '1) : (count == '0);

  // Next-state logic. rst is handled in the register process so that it
  // overrides everything computed here.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    presc_next = presc;
    count_next = count;
    tick_next  = 1'b0;
    tc_next    = 1'b0;

    if (load) begin
      // Load discards any coincident step and restarts the period.
      count_next = load_value;
      presc_next = '0;
    end else if (ce) begin
      if (presc == PRESC_LAST) begin
        presc_next = '0;
        tick_next  = 1'b1;
        tc_next    = at_bound;
        // In saturate mode a step at the bound is swallowed; otherwise the
        // modulo-2^WIDTH add/subtract gives the wrap for free.
        if (!(SATURATE && at_bound)) begin
          count_next = dir ? count + WIDTH'(1) : count - WIDTH'(1);
        end
      end else begin
        presc_next = presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      presc <= '0;
      count <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      presc <= presc_next;
      count <= count_next;
      tick  <= tick_next;
      tc    <= tc_next;
    end
  end

endmodule

// File: tb/tb_prescaled_counter.sv
// -----------------------------------------------------------------------------
// tb_prescaled_counter
//
// Three instances share one set of inputs:
//   [0] WIDTH=4, CYCLES_PER_TICK=4, wrap
//   [1] WIDTH=4, CYCLES_PER_TICK=4, saturate
//   [2] WIDTH=4, CYCLES_PER_TICK=1, wrap
// Each driven cycle pushes the expected outputs of all instances into a
// queue; after the edge they are popped and compared. Directed scenarios
// add explicit constant checks on top of the scoreboard.
// -----------------------------------------------------------------------------
module tb_prescaled_counter;

  localparam int N = 3;

  typedef struct {
    logic [3:0] count;
    logic       tick;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce = 1'b0;
  logic       dir = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;

  logic [3:0] count_o [N];
  logic       tick_o  [N];
  logic       tc_o    [N];

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];

  // Reference model state
  int cpt_of [N] = '{4, 4, 1};
  bit sat_of [N] = '{1'b0, 1'b1, 1'b0};
  int m_count [N];
  int m_presc [N];
  bit m_tick  [N];
  bit m_tc    [N];

  always #5 clk = ~clk;

  prescaled_counter #(.WIDTH(4), .CYCLES_PER_TICK(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .ce(ce), .dir(dir), .load(load),
    .load_value(load_value), .count(count_o[0]), .tick(tick_o[0]), .tc(tc_o[0])
  );

  prescaled_counter #(.WIDTH(4), .CYCLES_PER_TICK(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .ce(ce), .dir(dir), .load(load),
    .load_value(load_value), .count(count_o[1]), .tick(tick_o[1]), .tc(tc_o[1])
  );

  prescaled_counter #(.WIDTH(4), .CYCLES_PER_TICK(1), .SATURATE(1'b0)) u_fast (
    .clk(clk), .rst(rst), .ce(ce), .dir(dir), .load(load),
    .load_value(load_value), .count(count_o[2]), .tick(tick_o[2]), .tc(tc_o[2])
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance the behavioural model of instance i by one clock edge.
  task automatic model_edge(input int i, input bit r, input bit c, input bit d,
                            input bit l, input int lv);
    if (r) begin
      m_count[i] = 0; m_presc[i] = 0; m_tick[i] = 0; m_tc[i] = 0;
    end else if (l) begin
      m_count[i] = lv; m_presc[i] = 0; m_tick[i] = 0; m_tc[i] = 0;
    end else if (!c) begin
      m_tick[i] = 0; m_tc[i] = 0;
    end else if (m_presc[i] + 1 < cpt_of[i]) begin
      m_presc[i]++; m_tick[i] = 0; m_tc[i] = 0;
    end else begin
      m_presc[i] = 0;
      m_tick[i]  = 1;
      if (d) begin
        m_tc[i] = (m_count[i] == 15);
        if (m_count[i] == 15) m_count[i] = sat_of[i] ? 15 : 0;
        else m_count[i]++;
      end else begin
        m_tc[i] = (m_count[i] == 0);
        if (m_count[i] == 0) m_count[i] = sat_of[i] ? 0 : 15;
        else m_count[i]--;
      end
    end
  endtask

  // Drive one cycle of stimulus, push expectations, then compare after the edge.
  task automatic cyc(input bit r, input bit c, input bit d, input bit l,
                     input logic [3:0] lv);
    exp_t e;
    @(negedge clk);
    rst = r; ce = c; dir = d; load = l; load_value = lv;
    for (int i = 0; i < N; i++) begin
      model_edge(i, r, c, d, l, int'(lv));
      e.count = 4'(m_count[i]);
      e.tick  = m_tick[i];
      e.tc    = m_tc[i];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("sb%0d_count", i), int'(count_o[i]), int'(e.count));
        check($sformatf("sb%0d_tick", i), int'(tick_o[i]), int'(e.tick));
        check($sformatf("sb%0d_tc", i), int'(tc_o[i]), int'(e.tc));
      end
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_count[i] = 0; m_presc[i] = 0; m_tick[i] = 0; m_tc[i] = 0;
    end

    // Reset state
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    check("reset_count", int'(count_o[0]), 0);
    check("reset_tick", int'(tick_o[0]), 0);
    check("reset_tc", int'(tc_o[0]), 0);

    // Count up: first step after 4 edges, wrap to 0 after 64
    for (int k = 1; k <= 64; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      if (k == 3) check("up_before_step", int'(count_o[0]), 0);
      if (k == 4) begin
        check("up_first_count", int'(count_o[0]), 1);
        check("up_first_tick", int'(tick_o[0]), 1);
        check("up_first_tc", int'(tc_o[0]), 0);
      end
      if (k == 5) check("up_tick_one_cycle", int'(tick_o[0]), 0);
      if (k == 64) begin
        check("up_wrap_count", int'(count_o[0]), 0);
        check("up_wrap_tick", int'(tick_o[0]), 1);
        check("up_wrap_tc", int'(tc_o[0]), 1);
        check("up_sat_hold", int'(count_o[1]), 15);
      end
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check("up_wrap_tc_one_cycle", int'(tc_o[0]), 0);

    // Enable gating
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      check("gate_hold_count", int'(count_o[0]), 0);
      check("gate_no_tick", int'(tick_o[0]), 0);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check("gate_third_edge", int'(count_o[0]), 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check("gate_fourth_edge", int'(count_o[0]), 1);
    check("gate_tick", int'(tick_o[0]), 1);

    // Count-down wrap from reset
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    check("down_wrap_count", int'(count_o[0]), 15);
    check("down_wrap_tick", int'(tick_o[0]), 1);
    check("down_wrap_tc", int'(tc_o[0]), 1);
    check("down_sat_count", int'(count_o[1]), 0);
    check("down_sat_tc", int'(tc_o[1]), 1);

    // Saturation at the top, then stepping away
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd15);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      check("sat_hold_count", int'(count_o[1]), 15);
      check("sat_tick", int'(tick_o[1]), (k % 4 == 0) ? 1 : 0);
      check("sat_tc", int'(tc_o[1]), (k % 4 == 0) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    check("sat_down_count", int'(count_o[1]), 14);
    check("sat_down_tick", int'(tick_o[1]), 1);
    check("sat_down_tc", int'(tc_o[1]), 0);

    // Load mid-period, then load on a step edge
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
    check("load_count", int'(count_o[0]), 9);
    check("load_tick", int'(tick_o[0]), 0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check("load_no_early_step", int'(count_o[0]), 9);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check("load_then_step", int'(count_o[0]), 10);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
    check("load_on_step_count", int'(count_o[0]), 9);
    check("load_on_step_tick", int'(tick_o[0]), 0);
    check("load_on_step_tc", int'(tc_o[0]), 0);

    // Reset priority mid-period
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
    check("rst_prio_count", int'(count_o[0]), 0);
    check("rst_prio_tick", int'(tick_o[0]), 0);
    check("rst_prio_tc", int'(tc_o[0]), 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      check("rst_restart_tick", int'(tick_o[0]), (k == 4) ? 1 : 0);
    end
    check("rst_restart_count", int'(count_o[0]), 1);

    // Randomised traffic, all checked through the scoreboard
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(31) == 0, $urandom_range(3) != 0, 1'($urandom_range(1)),
          $urandom_range(7) == 0, 4'($urandom_range(15)));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net: the stimulus is finite, but never let the run hang.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prescaled_counter.md
PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the counter output width in bits (legal range 1..32).
REQ-002 SHALL have parameter CYCLES_PER_TICK, default 125000000, meaning the number of enabled clk cycles per count step (legal range 1..2^31-1).
REQ-003 SHALL have parameter SATURATE, default 0, meaning 0 = wrap at bounds, 1 = hold at bounds.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port ce, input, 1, the clock enable for the prescaler and the count step.
REQ-007 SHALL have port dir, input, 1, the step direction: 1 = up, 0 = down.
REQ-008 SHALL have port load, input, 1, a synchronous load strobe.
REQ-009 SHALL have port load_value, input, WIDTH, the value loaded when load=1.
REQ-010 SHALL have port count, output, WIDTH, the registered counter value.
REQ-011 SHALL have port tick, output, 1, a registered one-cycle pulse marking a count step.
REQ-012 SHALL have port tc, output, 1, a registered one-cycle terminal-count pulse.

Function
REQ-013 SHALL implement an internal prescaler of width max(1,$clog2(CYCLES_PER_TICK)) that counts 0..CYCLES_PER_TICK-1 on edges where ce=1 and holds where ce=0.
REQ-014 SHALL, on an edge where ce=1 and the prescaler equals CYCLES_PER_TICK-1 ("step edge"), clear the prescaler to 0 and step count.
REQ-015 SHALL, when CYCLES_PER_TICK=1, treat every edge with ce=1 as a step edge.
REQ-016 SHALL, at a step edge, use the value of dir sampled on that same edge.
REQ-017 SHALL, in wrap mode, step up from 2^WIDTH-1 to 0 and step down from 0 to 2^WIDTH-1, using modulo-2^WIDTH arithmetic.
REQ-018 SHALL, in saturate mode, hold count at 2^WIDTH-1 when stepping up and at 0 when stepping down.
REQ-019 SHALL set tick=1 for exactly the cycle following a step edge, so that tick is high in the same cycle count first shows the new value; tick SHALL be 0 otherwise.
REQ-020 SHALL set tc=1 coincident with tick when that step crossed or hit a bound: a wrap in wrap mode, or a step attempted at a bound in saturate mode; tc SHALL be 0 otherwise.
REQ-021 SHALL, on an edge with load=1, set count to load_value and the prescaler to 0, and drive tick=0 and tc=0 the following cycle, regardless of ce.
REQ-022 SHALL give load priority over a coincident step edge; the step is discarded.
REQ-023 SHALL keep count, the prescaler, tick and tc unchanged (tick/tc forced to 0) on edges where ce=0 and load=0.

Reset
REQ-024 SHALL, on an edge with rst=1, set count=0, prescaler=0, tick=0 and tc=0.
REQ-025 SHALL give rst priority over load and the step, including when rst arrives mid-period; the next period SHALL then start from prescaler 0.

Verification (WIDTH=4, CYCLES_PER_TICK=4 unless stated)
REQ-026 SHALL cover count-up: rst, then ce=1, dir=1 -> count=1 with a tick pulse after 4 edges; after 64 edges count=0 with tick=1 and tc=1 in that cycle only.
REQ-027 SHALL cover enable gating: ce=1 for 2 edges, ce=0 for 10 edges, then ce=1 for 2 edges -> count stays 0 while ce=0 and becomes 1 after the 4th enabled edge; no tick while ce=0.
REQ-028 SHALL cover count-down wrap: from reset with dir=0, ce=1 -> after 4 edges count=15 with tick=1 and tc=1.
REQ-029 SHALL cover saturation (SATURATE=1): load 15, dir=1, ce=1 -> count stays 15 and tick=tc=1 every 4th edge; then dir=0 -> count=14 with tc=0.
REQ-030 SHALL cover load: load 9 with load_value=9 after 2 enabled edges -> count=9 next cycle with tick=0; count=10 exactly 4 enabled edges after the load; load on a step edge yields 9, not a step.
REQ-031 SHALL cover reset priority: rst=1 with load=1 and load_value=7 mid-period -> count=0, tick=0, tc=0; first step occurs 4 enabled edges after rst deasserts.
